keyed_mux_lock_bank: RTL and testbench
======================================

Name: keyed_mux_lock_bank

Overview:
- Parametrised successor of our hard-wired 2-bit key-select MUX lock sites: NUM_SITES obfuscation muxes, each picking 1 of 2**SEL_W candidate nets under a key.
- Key is loaded serially into a shadow register, then committed atomically to an active register; mux outputs are registered.
- Sits between the locked combinational netlist's candidate nets and the gate inputs they replace, and gives the SAT/incremental-attack bench a clocked key-programming path.

Parameters:
- NUM_SITES, 5, number of lock mux sites.
- SEL_W, 2, select bits per site; NCAND = 2**SEL_W candidates per site.
- KEY_W, NUM_SITES*SEL_W, derived total key width; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_start  in  1  pulse; begins (or restarts) a serial key load.
- key_bit_valid  in  1  qualifies key_bit this cycle.
- key_bit  in  1  serial key data, LSB first.
- cand_i  in  NUM_SITES*NCAND  candidates; site s candidate c is cand_i[s*NCAND+c].
- mux_o  out  NUM_SITES  registered selected candidate per site.
- key_valid  out  1  active key committed and in use.
- key_busy  out  1  serial load in progress.
- key_err  out  1  sticky parity error (KEY_PARITY_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; shadow key, active key and bit counter = 0.
  - mux_o=0, key_valid=0, key_busy=0, key_err=0.
  - Reset mid-load abandons the load; the active key is also cleared.
- States: IDLE, LOAD, ARMED, ERR (ERR only with KEY_PARITY_EN).
- IDLE/ARMED/ERR:
  - key_bit_valid is ignored.
  - key_start -> LOAD next cycle: counter=0, shadow=0, key_err cleared, key_busy=1.
- LOAD:
  - Each key_bit_valid beat writes shadow[cnt]=key_bit, then cnt++. Non-valid cycles stall.
  - key_start in LOAD restarts: counter=0, shadow=0. Any key_bit_valid in that same cycle is dropped.
  - The beat with cnt==KEY_W-1 is the last key bit. Without parity: next cycle active<=shadow (with that bit), state=ARMED, key_valid=1, key_busy=0.
- The active key never changes during LOAD. mux_o keeps using the previous active key (or 0 if none) until commit.
- Mux select: site s select = active[s*SEL_W +: SEL_W]. mux_o[s] <= cand_i[s*NCAND+sel] every cycle in all states.
- Latency: cand_i change visible on mux_o at the next edge (1 cycle). New key affects mux_o from the edge after commit.
- Counter width: clog2(KEY_W+1). No wrap; it saturates at the terminal beat.

Optional Feature:
- Macro KEY_PARITY_EN.
- With it: LOAD takes KEY_W+1 beats; the final beat is an even-parity bit over the key.
  - Parity OK -> commit as above.
  - Mismatch -> ERR: active key cleared to 0, key_valid=0, key_busy=0, key_err=1 (sticky until rst or key_start).
- Without it: no parity beat, no ERR state; key_err tied 0.

Decomposition:
- Package lock_pkg: state enum (IDLE, LOAD, ARMED, ERR), function ncand(sel_w), function key_w(sites, sel_w).
- One sub-module keyed_mux_site: combinational NCAND:1 selector (SEL_W select, NCAND data, 1 out), instantiated NUM_SITES times.
- FSM, shadow/active registers and output flops stay in the top module.

Test Plan:
- Reset:
  - rst high 2 cycles with cand_i all 1 -> mux_o=0, key_valid=0 during reset.
  - One cycle after release -> mux_o=5'b11111 (key 0 selects candidate 0, all 1).
- Load and select (defaults):
  - key_start, then 10 beats LSB first of key 10'b11_10_01_00_11 -> key_valid=1 one cycle after the 10th beat.
  - Site selects are 3,0,1,2,3. Drive cand_i=1 only at indices {3,4,9,14,19} -> mux_o=5'b11111.
  - Drive cand_i=1 at index 0 only -> mux_o=5'b00000.
- Atomic commit:
  - While ARMED with the key above, start a new load and send 5 beats; toggle cand_i index 3 -> mux_o[0] follows it after 1 cycle.
  - key_valid stays 1 and the selects are unchanged.
- Restart and stall:
  - key_start after 7 beats, then 10 beats with gaps of 0-3 idle cycles -> the committed key equals only the last 10 bits.
  - A key_bit_valid coincident with that key_start is dropped.
- Reset mid-load:
  - rst at beat 4 -> state IDLE, active key 0, key_busy=0.
  - A subsequent full load of 10'h3FF -> all sites select candidate 3.
- Parity (KEY_PARITY_EN): 10'h001 with parity bit 1 -> ARMED; with parity bit 0 -> key_err=1, key_valid=0, mux_o tracks candidate 0; next key_start clears key_err.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the keyed MUX lock bank.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_ERR   = 2'd3
  } lock_state_e;

  function automatic int ncand(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic int key_w(input int sites, input int sel_w);
    return sites * sel_w;
  endfunction

endpackage

// File: rtl/keyed_mux_site.sv
// One lock site: combinational NCAND:1 selector driven by its slice of the active key.
module keyed_mux_site
  import lock_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]            i_sel,
  input  logic [lock_pkg::ncand(SEL_W)-1:0] i_data,
  output logic                        o_out
);

  assign o_out = i_data[i_sel];

endmodule

// File: rtl/keyed_mux_lock_bank.sv
// Bank of key-selected lock muxes with serial shadow-key load and atomic commit.
// Optional even-parity key beat and ERR state enabled by defining KEY_PARITY_EN.
//
// state | meaning
// IDLE  | no key loaded since reset, active key is 0
// LOAD  | shifting serial key bits into the shadow register
// ARMED | active key committed, key_valid high
// ERR   | parity beat mismatched, active key cleared (KEY_PARITY_EN only)
module keyed_mux_lock_bank
  import lock_pkg::*;
#(
  parameter int NUM_SITES = 5,
  parameter int SEL_W     = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        key_start,
  input  logic                                        key_bit_valid,
  input  logic                                        key_bit,
  input  logic [NUM_SITES*lock_pkg::ncand(SEL_W)-1:0] cand_i,
  output logic [NUM_SITES-1:0]                        mux_o,
  output logic                                        key_valid,
  output logic                                        key_busy,
  output logic                                        key_err
);

  localparam int NCAND = ncand(SEL_W);
  localparam int KEY_W = key_w(NUM_SITES, SEL_W);
  localparam int CNT_W = $clog2(KEY_W + 1);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD  = 2'(ST_LOAD);
  localparam logic [1:0] S_ARMED = 2'(ST_ARMED);
`ifdef KEY_PARITY_EN
  localparam logic [1:0] S_ERR   = 2'(ST_ERR);
`endif

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [KEY_W-1:0]     r_shadow;
  logic [KEY_W-1:0]     r_active;
  logic [NUM_SITES-1:0] r_mux;
  logic                 r_valid;
  logic                 r_busy;
`ifdef KEY_PARITY_EN
  logic                 r_err;
`endif

  logic                 w_beat;
  logic [KEY_W-1:0]     w_shadow_wr;
  logic [NUM_SITES-1:0] w_sel_out;

  // A key_start in LOAD takes priority, so a coincident beat is dropped.
  assign w_beat = (r_state == S_LOAD) && key_bit_valid && !key_start;

  always_comb begin
    w_shadow_wr = r_shadow;
    for (int i = 0; i < KEY_W; i++) begin
      if (w_beat && (r_cnt == CNT_W'(i))) begin
        w_shadow_wr[i] = key_bit;
      end
    end
  end

  for (genvar s = 0; s < NUM_SITES; s++) begin : g_site
    keyed_mux_site #(
      .SEL_W (SEL_W)
    ) u_site (
      .i_sel  (r_active[s*SEL_W +: SEL_W]),
      .i_data (cand_i[s*NCAND +: NCAND]),
      .o_out  (w_sel_out[s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_mux    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef KEY_PARITY_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_mux <= w_sel_out;
      case (r_state)
        S_LOAD: begin
          if (key_start) begin
            r_cnt    <= '0;
            r_shadow <= '0;
          end else if (key_bit_valid) begin
            r_shadow <= w_shadow_wr;
`ifdef KEY_PARITY_EN
            if (r_cnt == CNT_W'(KEY_W)) begin
              r_busy <= 1'b0;
              if ((^{r_shadow, key_bit}) == 1'b0) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
                r_state  <= S_ARMED;
              end else begin
                r_active <= '0;
                r_valid  <= 1'b0;
                r_err    <= 1'b1;
                r_state  <= S_ERR;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`else
            if (r_cnt == CNT_W'(KEY_W - 1)) begin
              r_active <= w_shadow_wr;
              r_valid  <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_ARMED;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          if (key_start) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
`ifdef KEY_PARITY_EN
            r_err    <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign mux_o     = r_mux;
  assign key_valid = r_valid;
  assign key_busy  = r_busy;
`ifdef KEY_PARITY_EN
  assign key_err   = r_err;
`else
  assign key_err   = 1'b0;
`endif

endmodule

// File: tb/tb_keyed_mux_lock_bank.sv
// Directed self-checking bench for keyed_mux_lock_bank at default parameters.
module tb_keyed_mux_lock_bank;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic        key_bit_valid;
  logic        key_bit;
  logic [19:0] cand_i;
  logic [4:0]  mux_o;
  logic        key_valid;
  logic        key_busy;
  logic        key_err;

  int n_checks;
  int n_errors;

  int gaps [10] = '{0, 1, 3, 2, 0, 1, 0, 3, 2, 1};

  localparam logic [9:0]  KEY_A  = 10'b11_10_01_00_11;
  localparam logic [9:0]  KEY_B  = 10'b00_10_11_01_00;
  localparam logic [19:0] C_A    = 20'h84218;
  localparam logic [19:0] C0_ALL = 20'h11111;
  localparam logic [19:0] C3_ALL = 20'h88888;

  keyed_mux_lock_bank u_dut (
    .clk           (clk),
    .rst           (rst),
    .key_start     (key_start),
    .key_bit_valid (key_bit_valid),
    .key_bit       (key_bit),
    .cand_i        (cand_i),
    .mux_o         (mux_o),
    .key_valid     (key_valid),
    .key_busy      (key_busy),
    .key_err       (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_mux(input logic [9:0] k, input logic [19:0] c);
    logic [4:0] r;
    logic [1:0] sel;
    for (int s = 0; s < 5; s++) begin
      sel  = k[2*s +: 2];
      r[s] = c[4*s + int'(sel)];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic b);
    key_bit_valid = 1'b1;
    key_bit       = b;
    tick();
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
  endtask

  task automatic start_load();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  task automatic send_bits(input logic [9:0] k, input bit use_gaps);
    for (int i = 0; i < 10; i++) begin
      send_beat(k[i]);
      if (use_gaps) begin
        for (int g = 0; g < gaps[i]; g++) tick();
      end
    end
  endtask

  task automatic send_key(input logic [9:0] k, input bit use_gaps);
    send_bits(k, use_gaps);
`ifdef KEY_PARITY_EN
    send_beat(^k);
`endif
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    key_start     = 1'b0;
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
    cand_i        = '1;

    tick();
    chk("rst_mux0", 32'(mux_o), 32'h00);
    chk("rst_valid0", 32'(key_valid), 32'h0);
    tick();
    chk("rst_mux1", 32'(mux_o), 32'h00);
    chk("rst_busy", 32'(key_busy), 32'h0);
    chk("rst_err", 32'(key_err), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_mux", 32'(mux_o), 32'h1F);
    chk("post_rst_valid", 32'(key_valid), 32'h0);

    // Idle ignores key bits.
    send_beat(1'b1);
    chk("idle_busy", 32'(key_busy), 32'h0);

    // Load KEY_A.
    start_load();
    chk("load_busy", 32'(key_busy), 32'h1);
    chk("load_valid", 32'(key_valid), 32'h0);
    send_key(KEY_A, 1'b0);
    chk("commit_valid", 32'(key_valid), 32'h1);
    chk("commit_busy", 32'(key_busy), 32'h0);
    cand_i = C_A;
    tick();
    chk("sel_a_ones", 32'(mux_o), 32'h1F);
    chk("sel_a_model", 32'(mux_o), 32'(exp_mux(KEY_A, C_A)));
    cand_i = 20'h00001;
    tick();
    chk("sel_a_idx0", 32'(mux_o), 32'h00);

    // Atomic commit: partial load must not disturb the active key.
    cand_i = C_A;
    start_load();
    chk("reload_busy", 32'(key_busy), 32'h1);
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    cand_i[3] = 1'b0;
    tick();
    chk("atomic_site0_lo", 32'(mux_o), 32'h1E);
    cand_i[3] = 1'b1;
    tick();
    chk("atomic_site0_hi", 32'(mux_o), 32'h1F);
    chk("atomic_valid", 32'(key_valid), 32'h1);

    // Restart after 7 beats, coincident beat dropped, gapped reload of KEY_B.
    start_load();
    for (int i = 0; i < 7; i++) send_beat(1'b1);
    key_start     = 1'b1;
    key_bit_valid = 1'b1;
    key_bit       = 1'b1;
    tick();
    key_start     = 1'b0;
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
    chk("restart_keep_a", 32'(mux_o), 32'h1F);
    send_key(KEY_B, 1'b1);
    chk("restart_valid", 32'(key_valid), 32'h1);
    cand_i = C0_ALL | C3_ALL;
    tick();
    chk("restart_b_mix", 32'(mux_o), 32'(exp_mux(KEY_B, cand_i)));
    cand_i = 20'h0B69E;
    tick();
    chk("restart_b_pat", 32'(mux_o), 32'(exp_mux(KEY_B, 20'h0B69E)));
    cand_i = ~C_A;
    tick();
    chk("restart_b_inv", 32'(mux_o), 32'(exp_mux(KEY_B, ~C_A)));

    // Armed ignores key bits.
    send_beat(1'b1);
    chk("armed_busy", 32'(key_busy), 32'h0);

    // Reset mid-load.
    start_load();
    for (int i = 0; i < 4; i++) send_beat(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(key_busy), 32'h0);
    chk("midrst_valid", 32'(key_valid), 32'h0);
    cand_i = C0_ALL;
    tick();
    chk("midrst_key0", 32'(mux_o), 32'h1F);
    start_load();
    send_key(10'h3FF, 1'b0);
    chk("ff_valid", 32'(key_valid), 32'h1);
    cand_i = C3_ALL;
    tick();
    chk("ff_sel3", 32'(mux_o), 32'h1F);
    cand_i = C0_ALL;
    tick();
    chk("ff_not0", 32'(mux_o), 32'h00);

`ifdef KEY_PARITY_EN
    start_load();
    send_bits(10'h001, 1'b0);
    chk("par_wait_busy", 32'(key_busy), 32'h1);
    send_beat(1'b1);
    chk("par_ok_valid", 32'(key_valid), 32'h1);
    chk("par_ok_err", 32'(key_err), 32'h0);
    start_load();
    send_bits(10'h001, 1'b0);
    send_beat(1'b0);
    chk("par_bad_err", 32'(key_err), 32'h1);
    chk("par_bad_valid", 32'(key_valid), 32'h0);
    chk("par_bad_busy", 32'(key_busy), 32'h0);
    cand_i = C0_ALL;
    tick();
    chk("par_bad_mux", 32'(mux_o), 32'h1F);
    tick();
    chk("par_err_sticky", 32'(key_err), 32'h1);
    start_load();
    chk("par_err_clr", 32'(key_err), 32'h0);
    chk("par_restart_busy", 32'(key_busy), 32'h1);
`else
    chk("no_par_err", 32'(key_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
